cellrv32_dmem_pipe: RTL and testbench

Parametrised processor-internal data memory: the successor to the fixed 32-bit, single-cycle DMEM. It adds a configurable data width, a configurable read latency of 1 or 2 cycles, and a hardware zero-fill engine that clears the whole array after reset or on request. It sits on the processor-internal bus next to IMEM/IO and keeps the same request/ticket/ack/err handshake.

---
 rtl/cellrv32_dmem_pipe.sv | 171 +++++++++++++++++
 tb/tb_cellrv32_dmem_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cellrv32_dmem_pipe.sv
// cellrv32_dmem_pipe: processor-internal data memory with configurable width,
// 1- or 2-cycle read latency and a hardware zero-fill engine.
//
// Bus handshake: a request is rden_i or wren_i high in a cycle whose address
// decodes to this memory. There is no ready/stall, so every such cycle is
// taken. Exactly READ_LATENCY cycles later, one single-cycle response appears:
// either ack_o (read or write done) or err_o (read+write together, or a request
// during zero-fill). ticket_o echoes ticket_i with the response. data_o carries
// read data only with a read ack. Outside a response, every output is zero.
module cellrv32_dmem_pipe #(
  parameter logic [31:0] DMEM_BASE      = 32'h0000_0000,
  parameter int          DMEM_SIZE      = 8192,
  parameter int          DATA_WIDTH     = 32,
  parameter int          READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    clr_i,
  input  logic                    rden_i,
  input  logic                    wren_i,
  input  logic [DATA_WIDTH/8-1:0] ben_i,
  input  logic [31:0]             addr_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [3:0]              ticket_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic [3:0]              ticket_o,
  output logic                    ack_o,
  output logic                    err_o,
  output logic                    busy_o
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OB    = $clog2(NB);
  localparam int WORDS = DMEM_SIZE / NB;
  localparam int AW    = $clog2(WORDS);
  localparam int SB    = $clog2(DMEM_SIZE);

  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_CLEAR = 1'b1;
  localparam logic [AW-1:0] PTR_LAST = AW'(WORDS - 1);

  // Bad parameter sets stop elaboration instead of building a broken memory.
  if (((DMEM_SIZE & (DMEM_SIZE - 1)) != 0) || (DMEM_SIZE < 4 * NB)) begin : g_bad_size
    $fatal(1, "cellrv32_dmem_pipe: DMEM_SIZE must be a power of two and hold at least 4 words");
  end
  if ((DATA_WIDTH != 32) && (DATA_WIDTH != 64)) begin : g_bad_width
    $fatal(1, "cellrv32_dmem_pipe: DATA_WIDTH must be 32 or 64");
  end
  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
    $fatal(1, "cellrv32_dmem_pipe: READ_LATENCY must be 1 or 2");
  end

  logic [0:0]            r_state;
  logic [AW-1:0]         r_ptr;
  logic                  w_acc_en;
  logic                  w_req;
  logic                  w_rd;
  logic                  w_wr;
  logic                  w_err;
  logic                  w_fill;
  logic [AW-1:0]         w_idx;
  logic [AW-1:0]         w_ram_addr;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [DATA_WIDTH-1:0] w_data1;
  logic                  r_ack1;
  logic                  r_err1;
  logic                  r_rd1;
  logic [3:0]            r_tkt1;
  logic                  w_unused;

  // Byte-offset bits never select anything; only whole words are addressed.
  assign w_unused = &{1'b0, addr_i[OB-1:0]};

  assign w_fill     = (r_state == ST_CLEAR);
  assign w_acc_en   = (addr_i[31:SB] == DMEM_BASE[31:SB]);
  assign w_req      = w_acc_en & (rden_i | wren_i);
  assign w_rd       = w_req & rden_i & ~wren_i & ~w_fill;
  assign w_wr       = w_req & wren_i & ~rden_i & ~w_fill;
  assign w_err      = w_req & ~w_rd & ~w_wr;
  assign w_idx      = addr_i[AW+OB-1:OB];
  assign w_ram_addr = w_fill ? r_ptr : w_idx;
  assign busy_o     = w_fill;

  // Zero-fill FSM: walk ptr over every word once, then return to IDLE.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      r_ptr   <= '0;
    end else if (r_state == ST_IDLE) begin
      if (clr_i) begin
        r_state <= ST_CLEAR;
        r_ptr   <= '0;
      end
    end else begin
      if (r_ptr == PTR_LAST) begin
        r_state <= ST_IDLE;
      end else begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  for (genvar l = 0; l < NB; l++) begin : g_lane
    logic [7:0] r_lane [0:WORDS-1];
    logic [7:0] r_q;
    logic       w_we;

    assign w_we = w_fill | (w_wr & ben_i[l]);
    assign w_rdata[8*l +: 8] = r_q;

    // One byte lane: fill/write port plus the registered read port.
    always_ff @(posedge clk_i) begin
      if (w_we) begin
        r_lane[w_ram_addr] <= w_fill ? 8'h00 : data_i[8*l +: 8];
      end
      r_q <= r_lane[w_ram_addr];
    end
  end

  // Response stage 1, aligned with the RAM read register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ack1 <= 1'b0;
      r_err1 <= 1'b0;
      r_rd1  <= 1'b0;
      r_tkt1 <= 4'h0;
    end else begin
      r_ack1 <= w_rd | w_wr;
      r_err1 <= w_err;
      r_rd1  <= w_rd;
      r_tkt1 <= w_req ? ticket_i : 4'h0;
    end
  end

  // RAM output is only visible with a read acknowledge.
  assign w_data1 = r_rd1 ? w_rdata : '0;

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  r_ack2;
    logic                  r_err2;
    logic [3:0]            r_tkt2;
    logic [DATA_WIDTH-1:0] r_data2;

    // Extra output register stage; takes a new response every cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        r_ack2  <= 1'b0;
        r_err2  <= 1'b0;
        r_tkt2  <= 4'h0;
        r_data2 <= '0;
      end else begin
        r_ack2  <= r_ack1;
        r_err2  <= r_err1;
        r_tkt2  <= r_tkt1;
        r_data2 <= w_data1;
      end
    end

    assign ack_o    = r_ack2;
    assign err_o    = r_err2;
    assign ticket_o = r_tkt2;
    assign data_o   = r_data2;
  end else begin : g_lat1
    assign ack_o    = r_ack1;
    assign err_o    = r_err1;
    assign ticket_o = r_tkt1;
    assign data_o   = w_data1;
  end

endmodule

// File: tb/tb_cellrv32_dmem_pipe.sv
// Bench for cellrv32_dmem_pipe: two instances sharing one request stream.
//   dut_a: 32-bit, READ_LATENCY 2, CLEAR_ON_RESET 1, 64 words.
//   dut_b: 64-bit, READ_LATENCY 1, CLEAR_ON_RESET 0, 32 words.
// A word-array reference model predicts every response and busy level.
module tb_cellrv32_dmem_pipe;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          SIZE = 256;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rstn;
  logic        clr, rden, wren;
  logic [7:0]  ben;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [3:0]  tkt;

  logic [31:0] a_data;
  logic [3:0]  a_tkt;
  logic        a_ack, a_err, a_busy;
  logic [63:0] b_data;
  logic [3:0]  b_tkt;
  logic        b_ack, b_err, b_busy;

  always #5 clk = ~clk;

  cellrv32_dmem_pipe #(
    .DMEM_BASE(BASE), .DMEM_SIZE(SIZE), .DATA_WIDTH(32),
    .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)
  ) dut_a (
    .clk_i(clk), .rstn_i(rstn), .clr_i(clr), .rden_i(rden), .wren_i(wren),
    .ben_i(ben[3:0]), .addr_i(addr), .data_i(wdata[31:0]), .ticket_i(tkt),
    .data_o(a_data), .ticket_o(a_tkt), .ack_o(a_ack), .err_o(a_err), .busy_o(a_busy)
  );

  cellrv32_dmem_pipe #(
    .DMEM_BASE(BASE), .DMEM_SIZE(SIZE), .DATA_WIDTH(64),
    .READ_LATENCY(1), .CLEAR_ON_RESET(1'b0)
  ) dut_b (
    .clk_i(clk), .rstn_i(rstn), .clr_i(clr), .rden_i(rden), .wren_i(wren),
    .ben_i(ben), .addr_i(addr), .data_i(wdata), .ticket_i(tkt),
    .data_o(b_data), .ticket_o(b_tkt), .ack_o(b_ack), .err_o(b_err), .busy_o(b_busy)
  );

  // ---------------- reference model + scoreboard ----------------
  // Response record: {ack, err, ticket[3:0], data[63:0]}.
  logic [63:0] m_mem [2][64];
  bit          m_busy [2];
  int          m_fill [2];
  logic [69:0] exp_q_a [$];
  logic [69:0] exp_q_b [$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Instance k: 0 -> 4 bytes/word, 1 -> 8 bytes/word; both 256 bytes at BASE.
  task automatic model_step(input int k, output logic [69:0] rsp);
    int         nb;
    int         idx;
    logic       ack;
    logic       err;
    logic [3:0] t;
    logic [63:0] d;
    nb  = (k == 0) ? 4 : 8;
    idx = int'(addr - BASE) / nb;
    ack = 1'b0; err = 1'b0; t = 4'h0; d = 64'h0;
    if (((addr >> 8) == (BASE >> 8)) && (rden || wren)) begin
      t = tkt;
      if (m_busy[k] || (rden && wren)) begin
        err = 1'b1;
      end else begin
        ack = 1'b1;
        if (rden) d = m_mem[k][idx];
        else for (int b = 0; b < nb; b++)
          if (ben[b]) m_mem[k][idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    if (m_busy[k]) begin
      m_fill[k]--;
      if (m_fill[k] == 0) m_busy[k] = 1'b0;
    end else if (clr) begin
      m_busy[k] = 1'b1;
      m_fill[k] = SIZE / nb;
      for (int w = 0; w < 64; w++) m_mem[k][w] = 64'h0;
    end
    rsp = {ack, err, t, d};
  endtask

  task automatic reset_model();
    m_busy[0] = 1'b1; m_fill[0] = SIZE / 4;
    for (int w = 0; w < 64; w++) m_mem[0][w] = 64'h0;
    m_busy[1] = 1'b0; m_fill[1] = 0;
    exp_q_a.delete(); exp_q_a.push_back(70'h0);   // latency 2: one empty slot
    exp_q_b.delete();
  endtask

  // One clock: model sees the inputs at the edge, outputs checked mid-cycle.
  task automatic step_cycle();
    logic [69:0] ra, rb;
    @(posedge clk);
    model_step(0, ra);
    model_step(1, rb);
    exp_q_a.push_back(ra);
    exp_q_b.push_back(rb);
    @(negedge clk);
    chk("a_rsp", {a_ack, a_err, a_tkt, 32'h0, a_data}, exp_q_a.pop_front());
    chk("b_rsp", {b_ack, b_err, b_tkt, b_data}, exp_q_b.pop_front());
    chk("a_busy", a_busy, m_busy[0]);
    chk("b_busy", b_busy, m_busy[1]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic w, input logic [7:0] be,
                       input logic [31:0] a, input logic [63:0] d,
                       input logic [3:0] t, input logic c);
    rden = r; wren = w; ben = be; addr = a; wdata = d; tkt = t; clr = c;
    step_cycle();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00, 32'h0, 64'h0, 4'h0, 1'b0);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      int          r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 15) == 0) a = $urandom;
      else a = BASE + $urandom_range(0, SIZE - 1);
      drive((r < 4) || (r == 8), ((r >= 4) && (r < 8)) || (r == 8), 8'($urandom), a,
            {$urandom, $urandom}, 4'($urandom), $urandom_range(0, 199) == 0);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    rstn = 1'b0; clr = 1'b0; rden = 1'b0; wren = 1'b0;
    ben = 8'h0; addr = 32'h0; wdata = 64'h0; tkt = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_a_rsp", {a_ack, a_err, a_tkt, a_data}, 38'h0);
    chk("rst_b_rsp", {b_ack, b_err, b_tkt, b_data}, 70'h0);
    chk("rst_a_busy", a_busy, 1'b1);
    chk("rst_b_busy", b_busy, 1'b0);
    reset_model();
    rstn = 1'b1;

    // Cycle 0: write + clr (b serves it then fills, a is mid reset-fill).
    drive(1'b0, 1'b1, 8'hFF, BASE + 32'h40, 64'h0123_4567_89AB_CDEF, 4'h3, 1'b1);
    drive(1'b1, 1'b0, 8'h00, BASE + 32'h08, 64'h0, 4'h5, 1'b0);
    drive(1'b1, 1'b1, 8'h00, BASE, 64'h0, 4'h6, 1'b0);
    idle(70);
    drive(1'b1, 1'b0, 8'h00, BASE + 32'h40, 64'h0, 4'h8, 1'b0);

    // Basic write then read, ticket echoed.
    drive(1'b0, 1'b1, 8'hFF, BASE + 32'h10, {32'hCAFEF00D, 32'hDEADBEEF}, 4'h2, 1'b0);
    drive(1'b1, 1'b0, 8'h00, BASE + 32'h10, 64'h0, 4'h9, 1'b0);

    // Partial byte enables over all-ones, then read with an odd byte offset.
    drive(1'b0, 1'b1, 8'hFF, BASE + 32'h18, {64{1'b1}}, 4'h1, 1'b0);
    drive(1'b0, 1'b1, 8'h55, BASE + 32'h18, {2{32'h11223344}}, 4'h2, 1'b0);
    drive(1'b1, 1'b0, 8'h00, BASE + 32'h18, 64'h0, 4'h3, 1'b0);
    drive(1'b1, 1'b0, 8'h00, BASE + 32'h1B, 64'h0, 4'h4, 1'b0);
    drive(1'b0, 1'b1, 8'h00, BASE + 32'h18, 64'h0, 4'h5, 1'b0);
    drive(1'b1, 1'b0, 8'h00, BASE + 32'h18, 64'h0, 4'h6, 1'b0);

    // Read+write collision must not touch memory; out-of-range is silent.
    drive(1'b1, 1'b1, 8'hFF, BASE + 32'h10, 64'h0, 4'hA, 1'b0);
    drive(1'b1, 1'b0, 8'h00, BASE + 32'h10, 64'h0, 4'hB, 1'b0);
    drive(1'b1, 1'b0, 8'h00, BASE + SIZE, 64'h0, 4'hC, 1'b0);
    drive(1'b0, 1'b1, 8'hFF, BASE - 32'h4, 64'h0, 4'hD, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 32'h8000_1010, 64'h0, 4'hE, 1'b0);

    // Software clear with a simultaneous read, re-pulse during the fill.
    drive(1'b0, 1'b1, 8'hFF, BASE + 32'h20, {2{32'hA5A5A5A5}}, 4'h4, 1'b0);
    drive(1'b1, 1'b0, 8'h00, BASE + 32'h20, 64'h0, 4'h7, 1'b1);
    idle(10);
    drive(1'b0, 1'b0, 8'h00, 32'h0, 64'h0, 4'h0, 1'b1);
    drive(1'b1, 1'b0, 8'h00, BASE + 32'h20, 64'h0, 4'hC, 1'b0);
    idle(60);
    drive(1'b1, 1'b0, 8'h00, BASE + 32'h20, 64'h0, 4'hF, 1'b0);

    // Random traffic, then let any fill finish.
    rand_cycles(1500);
    idle(70);

    // Back-to-back reads with reset asserted while responses are in flight.
    drive(1'b0, 1'b1, 8'hFF, BASE + 32'h30, {2{32'h5A5A_0F0F}}, 4'h1, 1'b0);
    drive(1'b1, 1'b0, 8'h00, BASE + 32'h30, 64'h0, 4'h2, 1'b0);
    drive(1'b1, 1'b0, 8'h00, BASE + 32'h30, 64'h0, 4'h3, 1'b0);
    rden = 1'b1; tkt = 4'h4;
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rstmid_a_rsp", {a_ack, a_err, a_tkt, a_data}, 38'h0);
    chk("rstmid_b_rsp", {b_ack, b_err, b_tkt, b_data}, 70'h0);
    chk("rstmid_a_busy", a_busy, 1'b1);
    chk("rstmid_b_busy", b_busy, 1'b0);
    rden = 1'b0; tkt = 4'h0; addr = 32'h0;
    reset_model();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    idle(80);
    drive(1'b1, 1'b0, 8'h00, BASE + 32'h30, 64'h0, 4'h9, 1'b0);
    rand_cycles(200);
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
